fw_hazard_unit: RTL

//  Parametrised forwarding and hazard unit for the ARM pipeline. Replaces the fixed MEM/WB 2-source mux selector.

---
 rtl/fw_pkg.sv | 25 ++
 rtl/fw_tag_stage.sv | 34 +++
 rtl/fw_hazard_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fw_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
// A tag describes the producer that left EX some number of advances ago.
package fw_pkg;

    // Tags store addresses zero-extended to this width.
    // REG_ADDR_W in fw_hazard_unit must not exceed it.
    localparam int FW_ADDR_MAX_W  = 16;
    localparam int FW_SEL_REGFILE = 0;

    typedef struct packed {
        logic                     valid;
        logic [FW_ADDR_MAX_W-1:0] dest;
        logic                     wb_en;
        logic                     mem_read;
    } fw_tag_t;

    localparam fw_tag_t FW_TAG_BUBBLE = '0;

    function automatic logic fw_match(input fw_tag_t                  tag,
                                      input logic [FW_ADDR_MAX_W-1:0] addr,
                                      input logic                     src_valid);
        return src_valid & tag.valid & tag.wb_en & (tag.dest == addr);
    endfunction

endpackage

// File: rtl/fw_tag_stage.sv
// One producer-tag register with bubble > load > hold priority.
module fw_tag_stage
    import fw_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  logic    bubble_i,
    input  fw_tag_t tag_i,
    output fw_tag_t tag_o
);

    fw_tag_t tag_q, tag_d;

    always_comb begin
        tag_d = tag_q;
        if (bubble_i) begin
            tag_d = FW_TAG_BUBBLE;
        end else if (load_i) begin
            tag_d = tag_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= FW_TAG_BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/fw_hazard_unit.sv
// Forwarding select and load-use/interlock stall generation over FWD_DEPTH tracked producer stages.
// Optional FW_STATS_EN adds saturating fwd_count/stall_count event counters.
module fw_hazard_unit
    import fw_pkg::*;
#(
    parameter  int REG_ADDR_W = 4,
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_DEPTH  = 2,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fw_en,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic                          ex_valid,
    input  logic [REG_ADDR_W-1:0]         ex_dest,
    input  logic                          ex_wb_en,
    input  logic                          ex_mem_read,
    input  logic                          freeze,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      sel_src,
    output logic                          stall
`ifdef FW_STATS_EN
    ,
    output logic [31:0]                   fwd_count,
    output logic [31:0]                   stall_count
`endif
);

    fw_tag_t                  ex_tag;
    fw_tag_t                  stage_tag [1:FWD_DEPTH];
    logic [FW_ADDR_MAX_W-1:0] src_addr_ext [NUM_SRC];
    logic [NUM_SRC-1:0]       found;
    logic                     load_use;
    logic                     raw_hit;

    always_comb begin
        ex_tag                         = FW_TAG_BUBBLE;
        ex_tag.valid                   = ex_valid;
        ex_tag.dest[REG_ADDR_W-1:0]    = ex_dest;
        ex_tag.wb_en                   = ex_wb_en & ex_valid;
        ex_tag.mem_read                = ex_mem_read & ex_valid;
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_addr_ext[i] = FW_ADDR_MAX_W'(src_addr[i*REG_ADDR_W +: REG_ADDR_W]);
        end
    end

    for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_stage
        fw_tag_t tag_in;
        logic    load;
        logic    bubble;

        if (k == 1) begin : g_first
            assign tag_in = ex_tag;
        end else begin : g_rest
            assign tag_in = stage_tag[k-1];
        end

        // Flush lets only the oldest stage advance; with a single stage there is nothing older to keep.
        always_comb begin
            load   = 1'b0;
            bubble = 1'b0;
            if (flush) begin
                if (k < FWD_DEPTH || FWD_DEPTH == 1) begin
                    bubble = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end else if (!freeze) begin
                if (stall && k == 1) begin
                    bubble = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
        end

        fw_tag_stage u_stage (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load),
            .bubble_i (bubble),
            .tag_i    (tag_in),
            .tag_o    (stage_tag[k])
        );
    end

    // Youngest match wins; the last stage writes the regfile early enough that it never interlocks.
    always_comb begin
        sel_src  = {NUM_SRC{SEL_W'(FW_SEL_REGFILE)}};
        found    = '0;
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                if (fw_match(stage_tag[k], src_addr_ext[i], src_valid[i])) begin
                    if (!found[i]) begin
                        found[i]                  = 1'b1;
                        sel_src[i*SEL_W +: SEL_W] = SEL_W'(k);
                        if (k == 1 && stage_tag[1].mem_read) begin
                            load_use = 1'b1;
                        end
                    end
                    if (k < FWD_DEPTH) begin
                        raw_hit = 1'b1;
                    end
                end
            end
        end
        if (!fw_en) begin
            sel_src = {NUM_SRC{SEL_W'(FW_SEL_REGFILE)}};
        end
    end

    assign stall = ex_valid & ~flush & (fw_en ? load_use : raw_hit);

`ifdef FW_STATS_EN
    logic [31:0] fwd_count_q, fwd_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [32:0] fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_inc = fwd_inc + 33'(|sel_src[i*SEL_W +: SEL_W]);
        end
        fwd_sum       = {1'b0, fwd_count_q} + fwd_inc;
        fwd_count_d   = fwd_count_q;
        stall_count_d = stall_count_q;
        if (!freeze) begin
            if (stall) begin
                if (stall_count_q != 32'hFFFF_FFFF) begin
                    stall_count_d = stall_count_q + 32'd1;
                end
            end else begin
                fwd_count_d = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            fwd_count_q   <= fwd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
